// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared types and helpers for the pixel-clock capture path.
//   rgb_t            : packed {r, g, b} byte triple, matches vid_rgb bit order
//   capture_state_t  : capture FSM states
//   SYNC_ACTIVE_LVL  : level of HS/VS while the sync pulse is asserted
//   BLANK_ACTIVE_LVL : level of vid_blank while a pixel is active
//   pack_pixel()     : rgb_t -> 32-bit FIFO word {8'h00, r, g, b}
// ---------------------------------------------------------------------------
package video_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        ACTIVE,
        DROP
    } capture_state_t;

    localparam logic SYNC_ACTIVE_LVL  = 1'b0;
    localparam logic BLANK_ACTIVE_LVL = 1'b1;

    function automatic logic [31:0] pack_pixel(input rgb_t rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/video_edge_det.sv
// ---------------------------------------------------------------------------
// video_edge_det
// Two-stage register on the incoming video_if signals, with edge pulses
// derived between stage 1 (newer) and stage 2 (older).
//   pixel_clk, pixel_rst : clock, asynchronous active-high reset
//   vid_hs/vs/blank/rgb  : raw interface inputs
//   s1_blank, s1_rgb     : stage-1 pixel qualifier and colour
//   vs_fall              : VS entered its active (low) level
//   blank_fall           : active video just ended (end of line)
//   hs_fall              : HS entered its active (low) level
// Stages reset to 0 so a sync already low at reset release is not
// mistaken for a fresh falling edge.
// ---------------------------------------------------------------------------
module video_edge_det
    import video_pkg::*;
(
    input  logic pixel_clk,
    input  logic pixel_rst,
    input  logic vid_hs,
    input  logic vid_vs,
    input  logic vid_blank,
    input  rgb_t vid_rgb,
    output logic s1_blank,
    output rgb_t s1_rgb,
    output logic vs_fall,
    output logic blank_fall,
    output logic hs_fall
);

    logic s1_hs, s1_vs;
    logic s2_hs, s2_vs, s2_blank;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_blank <= 1'b0;
            s1_rgb   <= '0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
            s2_blank <= 1'b0;
        end else begin
            s1_hs    <= vid_hs;
            s1_vs    <= vid_vs;
            s1_blank <= vid_blank;
            s1_rgb   <= vid_rgb;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
            s2_blank <= s1_blank;
        end
    end

    assign vs_fall    = (s2_vs != SYNC_ACTIVE_LVL) && (s1_vs == SYNC_ACTIVE_LVL);
    assign hs_fall    = (s2_hs != SYNC_ACTIVE_LVL) && (s1_hs == SYNC_ACTIVE_LVL);
    assign blank_fall = (s2_blank == BLANK_ACTIVE_LVL) && (s1_blank != BLANK_ACTIVE_LVL);

endmodule

// File: rtl/video_capture.sv
// ---------------------------------------------------------------------------
// video_capture
// Receives the video_if pixel stream, locks to frame boundaries, checks
// active geometry against HDISP x VDISP and pushes active pixels into the
// write port of an async FIFO, one per cycle.
//
// Parameters: HDISP (active pixels per line), VDISP (active lines per frame)
// Ports:
//   pixel_clk, pixel_rst     : clock, asynchronous active-high reset
//   vid_hs, vid_vs           : line/frame sync, active low
//   vid_blank, vid_rgb       : 1 = active pixel, {R,G,B}
//   enable                   : capture request, honoured in IDLE and at VS fall
//   fifo_wfull               : FIFO full, already in pixel_clk domain
//   fifo_write, fifo_wdata   : FIFO write strobe / {8'h00, rgb}
//   sof, frame_done          : first-pixel and end-of-frame pulses
//   locked                   : last completed frame was clean
//   err_overflow, err_geometry, err_clr : sticky errors and their clear
// Optional (macro VIDEO_CAPTURE_STATS_EN):
//   frame_cnt, meas_hpix, meas_vlines : frame count and last measured geometry
//
// Timing: a pixel launched onto vid_* at edge n is in stage 1 after edge
// n+1 and appears on fifo_write/fifo_wdata after edge n+2.
// ---------------------------------------------------------------------------
module video_capture
    import video_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        vid_hs,
    input  logic        vid_vs,
    input  logic        vid_blank,
    input  logic [23:0] vid_rgb,
    input  logic        enable,
    input  logic        fifo_wfull,
    output logic        fifo_write,
    output logic [31:0] fifo_wdata,
    output logic        sof,
    output logic        frame_done,
    output logic        locked,
    output logic        err_overflow,
    output logic        err_geometry,
`ifdef VIDEO_CAPTURE_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [15:0] meas_hpix,
    output logic [15:0] meas_vlines,
`endif
    input  logic        err_clr
);

    localparam int XW = $clog2(HDISP + 1);
    localparam int YW = $clog2(VDISP + 1);
    localparam logic [XW-1:0] X_MAX = XW'(HDISP);
    localparam logic [YW-1:0] Y_MAX = YW'(VDISP);

    logic s1_blank;
    rgb_t s1_rgb;
    logic vs_fall, blank_fall;
    // Frames are delimited by VS and BLANK alone; line sync is not needed.
    logic unused_hs_fall;

    video_edge_det u_edge (
        .pixel_clk  (pixel_clk),
        .pixel_rst  (pixel_rst),
        .vid_hs     (vid_hs),
        .vid_vs     (vid_vs),
        .vid_blank  (vid_blank),
        .vid_rgb    (vid_rgb),
        .s1_blank   (s1_blank),
        .s1_rgb     (s1_rgb),
        .vs_fall    (vs_fall),
        .blank_fall (blank_fall),
        .hs_fall    (unused_hs_fall)
    );

    capture_state_t state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           ferr_q, ferr_d;
    logic           locked_d, ovf_d, geo_d;
    logic           write_d, sof_d, done_d;
    logic [31:0]    wdata_d;
    logic           pix;

    assign pix = (s1_blank == BLANK_ACTIVE_LVL);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            ferr_q       <= 1'b0;
            locked       <= 1'b0;
            err_overflow <= 1'b0;
            err_geometry <= 1'b0;
            fifo_write   <= 1'b0;
            fifo_wdata   <= '0;
            sof          <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            ferr_q       <= ferr_d;
            locked       <= locked_d;
            err_overflow <= ovf_d;
            err_geometry <= geo_d;
            fifo_write   <= write_d;
            fifo_wdata   <= wdata_d;
            sof          <= sof_d;
            frame_done   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        ferr_d   = ferr_q;
        locked_d = locked;
        // Clear first so that an error raised in the same cycle wins.
        ovf_d    = err_clr ? 1'b0 : err_overflow;
        geo_d    = err_clr ? 1'b0 : err_geometry;
        write_d  = 1'b0;
        sof_d    = 1'b0;
        done_d   = 1'b0;
        wdata_d  = fifo_wdata;

        unique case (state_q)
            IDLE: begin
                if (enable) state_d = SYNC;
            end

            SYNC: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = '0;
                    ferr_d  = 1'b0;
                end
            end

            ACTIVE: begin
                if (pix) begin
                    if (fifo_wfull) begin
                        // The frame error flag also covers overflow so a
                        // coincident VS fall cannot report the frame as clean.
                        ovf_d    = 1'b1;
                        locked_d = 1'b0;
                        ferr_d   = 1'b1;
                        state_d  = DROP;
                    end else if ((x_q >= X_MAX) || (y_q >= Y_MAX)) begin
                        geo_d  = 1'b1;
                        ferr_d = 1'b1;
                    end else begin
                        write_d = 1'b1;
                        wdata_d = pack_pixel(s1_rgb);
                        sof_d   = (x_q == '0) && (y_q == '0);
                        x_d     = x_q + 1'b1;
                    end
                end

                // Line end is handled before frame end when both coincide.
                if (blank_fall) begin
                    if (x_q != X_MAX) begin
                        geo_d  = 1'b1;
                        ferr_d = 1'b1;
                    end
                    x_d = '0;
                    // Saturate: once past VDISP the frame is already in error
                    // and the counter must not wrap back into range.
                    if (y_q < Y_MAX) y_d = y_q + 1'b1;
                end

                if (vs_fall) begin
                    if (y_d != Y_MAX) begin
                        geo_d  = 1'b1;
                        ferr_d = 1'b1;
                    end
                    done_d   = 1'b1;
                    locked_d = ~ferr_d;
                    x_d      = '0;
                    y_d      = '0;
                    ferr_d   = 1'b0;
                    state_d  = enable ? ACTIVE : IDLE;
                end
            end

            DROP: begin
                if (vs_fall) begin
                    done_d  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    ferr_d  = 1'b0;
                    state_d = enable ? ACTIVE : IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

`ifdef VIDEO_CAPTURE_STATS_EN
    // Line count as seen by the VS check, i.e. including a line ending in
    // the same cycle.
    logic [YW-1:0] lines_seen;
    assign lines_seen = (blank_fall && (y_q < Y_MAX)) ? y_q + 1'b1 : y_q;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            frame_cnt   <= '0;
            meas_hpix   <= '0;
            meas_vlines <= '0;
        end else begin
            if (done_d) frame_cnt <= frame_cnt + 16'd1;
            if ((state_q == ACTIVE) && blank_fall) meas_hpix <= 16'(x_q);
            if ((state_q == ACTIVE) && vs_fall) meas_vlines <= 16'(lines_seen);
        end
    end
`endif

endmodule

// File: tb/tb_video_capture.sv
// ---------------------------------------------------------------------------
// tb_video_capture
// Self-checking bench for video_capture with HDISP=16, VDISP=4.
// A small timing generator drives lines/frames; every pixel the capture is
// expected to write is pushed to exp_q (with its sof bit and launch cycle)
// and popped by a monitor on each fifo_write. Per-frame totals (writes,
// sof, frame_done) and status flags are checked after each frame.
// Build with VIDEO_CAPTURE_STATS_EN to also check the statistics outputs.
// ---------------------------------------------------------------------------
module tb_video_capture;

    localparam int HD = 16;
    localparam int VD = 4;
    localparam int NO_WF = -100;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic        vid_hs    = 1'b1;
    logic        vid_vs    = 1'b1;
    logic        vid_blank = 1'b0;
    logic [23:0] vid_rgb   = '0;
    logic        enable    = 1'b0;
    logic        fifo_wfull = 1'b0;
    logic        err_clr   = 1'b0;
    logic        fifo_write, sof, frame_done, locked, err_overflow, err_geometry;
    logic [31:0] fifo_wdata;
`ifdef VIDEO_CAPTURE_STATS_EN
    logic [15:0] frame_cnt, meas_hpix, meas_vlines;
`endif

    video_capture #(.HDISP(HD), .VDISP(VD)) dut (
        .pixel_clk    (pixel_clk),
        .pixel_rst    (pixel_rst),
        .vid_hs       (vid_hs),
        .vid_vs       (vid_vs),
        .vid_blank    (vid_blank),
        .vid_rgb      (vid_rgb),
        .enable       (enable),
        .fifo_wfull   (fifo_wfull),
        .fifo_write   (fifo_write),
        .fifo_wdata   (fifo_wdata),
        .sof          (sof),
        .frame_done   (frame_done),
        .locked       (locked),
        .err_overflow (err_overflow),
        .err_geometry (err_geometry),
`ifdef VIDEO_CAPTURE_STATS_EN
        .frame_cnt    (frame_cnt),
        .meas_hpix    (meas_hpix),
        .meas_vlines  (meas_vlines),
`endif
        .err_clr      (err_clr)
    );

    // ---------------- clock / reset ----------------
    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];
    int          exp_t[$];
    int n_wr = 0, n_sof = 0, n_done = 0;
    logic [31:0] last_wdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge pixel_clk) begin
        logic [32:0] item;
        int t;
        if (pixel_rst) begin
            last_wdata = '0;
        end else begin
            if (frame_done) n_done++;
            if (fifo_write) begin
                n_wr++;
                if (sof) n_sof++;
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    item = exp_q.pop_front();
                    t    = exp_t.pop_front();
                    check("wdata", 64'(fifo_wdata), 64'(item[31:0]));
                    check("sof", 64'(sof), 64'(item[32]));
                    check("latency", 64'(cyc - t), 64'd2);
                end
                last_wdata = fifo_wdata;
            end else begin
                check("sof_without_write", 64'(sof), 64'd0);
                check("wdata_hold", 64'(fifo_wdata), 64'(last_wdata));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input logic h, input logic v, input logic b, input logic [23:0] rgb);
        vid_hs = h; vid_vs = v; vid_blank = b; vid_rgb = rgb;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic vs_pulse();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic line_blank();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic push_pix(input int l, input int x);
        exp_q.push_back({(l == 0) && (x == 0), 8'h00, 8'(l), 8'(x), 8'h5a});
        exp_t.push_back(cyc);
    endtask

    // Pixels x < lim are expected to be written. fifo_wfull rises together
    // with pixel wf_at and stays high for 3 cycles; since the capture decides
    // on the stage-1 pixel, the first dropped pixel is wf_at-1.
    task automatic send_line(input int l, input int len, input int lim, input int wf_at);
        for (int x = 0; x < len; x++) begin
            if (x == wf_at) fifo_wfull = 1'b1;
            if (x == wf_at + 3) fifo_wfull = 1'b0;
            if (x < lim) push_pix(l, x);
            step(1'b1, 1'b1, 1'b1, {8'(l), 8'(x), 8'h5a});
        end
        fifo_wfull = 1'b0;
        line_blank();
    endtask

    task automatic frame(input bit push, input int short_line, input int nlines,
                         input bit ovf, input int en_line,
                         input int wr_exp, input int sof_exp, input int done_exp,
                         input logic locked_exp, input string tag);
        int w0, s0, d0, len, lim, wf;
        w0 = n_wr; s0 = n_sof; d0 = n_done;
        for (int l = 0; l < nlines; l++) begin
            if (l == en_line) enable = 1'b1;
            len = (l == short_line) ? HD - 1 : HD;
            lim = (push && l < VD) ? len : 0;
            wf  = NO_WF;
            if (ovf && l == 2) begin
                lim = 4;
                wf  = 5;
            end else if (ovf && l > 2) begin
                lim = 0;
            end
            send_line(l, len, lim, wf);
        end
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        vs_pulse();
        check({tag, "_writes"}, 64'(n_wr - w0), 64'(wr_exp));
        check({tag, "_sof"}, 64'(n_sof - s0), 64'(sof_exp));
        check({tag, "_done"}, 64'(n_done - d0), 64'(done_exp));
        check({tag, "_locked"}, 64'(locked), 64'(locked_exp));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        step(1'b1, 1'b1, 1'b0, '0);
        err_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fifo_write"}, 64'(fifo_write), 64'd0);
        check({tag, "_fifo_wdata"}, 64'(fifo_wdata), 64'd0);
        check({tag, "_sof"}, 64'(sof), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_locked"}, 64'(locked), 64'd0);
        check({tag, "_err_overflow"}, 64'(err_overflow), 64'd0);
        check({tag, "_err_geometry"}, 64'(err_geometry), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_all_zero("reset");
        pixel_rst = 1'b0;
        enable = 1'b1;
        repeat (3) step(1'b1, 1'b1, 1'b0, '0);
        vs_pulse();

        // Loopback, two clean frames.
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "frame0");
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "frame1");
`ifdef VIDEO_CAPTURE_STATS_EN
        check("meas_hpix", 64'(meas_hpix), 64'd16);
        check("meas_vlines", 64'(meas_vlines), 64'd4);
`endif

        // Enable dropped inside a frame: that frame completes, then IDLE.
        enable = 1'b0;
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "en_drop");
        // Enable rises mid-frame: nothing until the next VS fall.
        frame(1'b0, -1, VD, 1'b0, 2, 0, 0, 0, 1'b1, "en_mid");
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "en_resume");

        // Overflow on line 2.
        frame(1'b1, -1, VD, 1'b1, -1, 36, 1, 1, 1'b0, "overflow");
        check("ovf_err_overflow", 64'(err_overflow), 64'd1);
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "ovf_recover");
        check("ovf_sticky", 64'(err_overflow), 64'd1);
        clear_errors();
        check("ovf_cleared", 64'(err_overflow), 64'd0);

        // 15-pixel line.
        frame(1'b1, 1, VD, 1'b0, -1, 63, 1, 1, 1'b0, "short_line");
        check("short_err_geometry", 64'(err_geometry), 64'd1);
        clear_errors();
        check("short_cleared", 64'(err_geometry), 64'd0);
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "short_recover");

        // Fifth active line is not written.
        frame(1'b1, -1, VD + 1, 1'b0, -1, 64, 1, 1, 1'b0, "extra_line");
        check("extra_err_geometry", 64'(err_geometry), 64'd1);
        clear_errors();
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "extra_recover");

        // Reset in the middle of line 1.
        send_line(0, HD, HD, NO_WF);
        for (int x = 0; x < 8; x++) begin
            push_pix(1, x);
            step(1'b1, 1'b1, 1'b1, {8'd1, 8'(x), 8'h5a});
        end
        #2;
        pixel_rst = 1'b1;
        #1;
        check_all_zero("midline_rst");
        exp_q.delete();
        exp_t.delete();
        for (int x = 8; x < HD; x++) begin
            if (x == 11) pixel_rst = 1'b0;
            step(1'b1, 1'b1, 1'b1, {8'd1, 8'(x), 8'h5a});
        end
        w0 = n_wr;
        line_blank();
        send_line(2, HD, 0, NO_WF);
        send_line(3, HD, 0, NO_WF);
        step(1'b1, 1'b1, 1'b0, '0);
        check("post_rst_no_writes", 64'(n_wr - w0), 64'd0);
        check("post_rst_locked", 64'(locked), 64'd0);
        vs_pulse();
        frame(1'b1, -1, VD, 1'b0, -1, 64, 1, 1, 1'b1, "post_rst");
`ifdef VIDEO_CAPTURE_STATS_EN
        check("frame_cnt", 64'(frame_cnt), 64'd1);
`endif

        repeat (4) step(1'b1, 1'b1, 1'b0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
